// File: rtl/pe_pkg.sv
// Shared constants for the pe_8b priority encoder and its idx_dec_8b companion.
// Holds the default width, index-width helper and error-flag bit positions.
package pe_pkg;

    localparam int unsigned pe_w = 8;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? int'($clog2(w)) : 1;
    endfunction

    localparam int unsigned pe_idx_w = idx_width(pe_w);

    localparam int unsigned err_n       = 3;
    localparam int unsigned err_dup_bit = 0;
    localparam int unsigned err_unf_bit = 1;
    localparam int unsigned err_rng_bit = 2;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decoder with an in-range flag.
// Produces no bit when disabled or when the index exceeds the vector width.
module onehot_dec #(
    parameter int unsigned w_idx = 3,
    parameter int unsigned w_out = 8
) (
    input  logic             en,
    input  logic [w_idx-1:0] idx,
    output logic [w_out-1:0] oh_c,
    output logic             in_rng_c
);

    always_comb begin
        in_rng_c = (32'(idx) < w_out);
        oh_c     = '0;
        for (int unsigned i = 0; i < w_out; i++) begin
            oh_c[i] = en && in_rng_c && (idx == w_idx'(i));
        end
    end

endmodule

// File: rtl/idx_dec_8b.sv
// Registered pending-bit vector driven by decoded set/clear requests.
// Tracks count, full/empty, sticky protocol errors and pulses each accepted set.
module idx_dec_8b
    import pe_pkg::*;
#(
    parameter  int unsigned w_out = pe_w,
    localparam int unsigned w_idx = idx_width(w_out)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_val,
    input  logic [w_idx-1:0] set_idx,
    input  logic             clr_val,
    input  logic [w_idx-1:0] clr_idx,
    input  logic             err_clr,
    output logic [w_out-1:0] pend,
    output logic [w_out-1:0] dec,
    output logic             dec_val,
    output logic [w_idx:0]   cnt,
    output logic             full,
    output logic             empty,
    output logic             err_dup,
    output logic             err_unf,
    output logic             err_rng
);

    localparam int unsigned cnt_w = w_idx + 1;

    function automatic logic [cnt_w-1:0] popcount(input logic [w_out-1:0] v);
        logic [cnt_w-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < w_out; i++) begin
            sum = sum + cnt_w'(v[i]);
        end
        return sum;
    endfunction

    logic [w_out-1:0] set_oh, clr_oh;
    logic             set_rng, clr_rng;

    onehot_dec #(.w_idx(w_idx), .w_out(w_out)) u_set_dec (
        .en       (set_val),
        .idx      (set_idx),
        .oh_c     (set_oh),
        .in_rng_c (set_rng)
    );

    onehot_dec #(.w_idx(w_idx), .w_out(w_out)) u_clr_dec (
        .en       (clr_val),
        .idx      (clr_idx),
        .oh_c     (clr_oh),
        .in_rng_c (clr_rng)
    );

    logic [w_out-1:0] pend_q, pend_d;
    logic [w_out-1:0] dec_q, dec_d;
    logic             dec_val_q, dec_val_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [err_n-1:0] err_q, err_d;
    logic [err_n-1:0] err_new;

    // Clear applies before set, so a same-index set+clear leaves the bit at 1.
    always_comb begin
        err_new = '0;
        err_new[err_dup_bit] = |(set_oh & pend_q & ~clr_oh);
        err_new[err_unf_bit] = |(clr_oh & ~pend_q);
        err_new[err_rng_bit] = (set_val && !set_rng) || (clr_val && !clr_rng);

        pend_d    = (pend_q & ~clr_oh) | set_oh;
        dec_d     = set_oh;
        dec_val_d = |set_oh;
        cnt_d     = popcount(pend_d);
        full_d    = &pend_d;
        empty_d   = ~|pend_d;
        err_d     = (err_clr ? '0 : err_q) | err_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            dec_q     <= '0;
            dec_val_q <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            err_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            dec_q     <= dec_d;
            dec_val_q <= dec_val_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            err_q     <= err_d;
        end
    end

    assign pend    = pend_q;
    assign dec     = dec_q;
    assign dec_val = dec_val_q;
    assign cnt     = cnt_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign err_dup = err_q[err_dup_bit];
    assign err_unf = err_q[err_unf_bit];
    assign err_rng = err_q[err_rng_bit];

endmodule
